johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
- Receive-side companion of the team's Johnson counter.
- Samples an N-bit Johnson-coded word on each enabled cycle and decodes it to a binary step index and a one-hot vector.
- Checks that every code is legal and that successive codes advance by exactly one step; reports errors and lock status.
- Sits downstream of johnson_counter (or any Johnson-coded source) as a decoder and link monitor.

Parameters:
N, 4, Johnson register width; sequence length is 2N.
ERRW, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous active-high reset.
enable  input  1  sample strobe; q_in is evaluated only when 1; each assertion means the source advanced one step.
q_in  input  N  Johnson-coded word from the counter.
count  output  $clog2(2N)  decoded step index 0..2N-1.
onehot  output  2N  one-hot of count; all zeros when not valid.
valid  output  1  count/onehot hold a legal decode from the most recent sample.
locked  output  1  the sequence is tracking correctly.
code_err  output  1  one-cycle pulse: illegal code sampled.
seq_err  output  1  one-cycle pulse: legal code sampled that is not prev+1 mod 2N while locked.
err_cnt  output  ERRW  saturating count of code_err plus seq_err events.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=0, onehot=0, valid=0, locked=0, code_err=0, seq_err=0, err_cnt=0, prev=0, state=SEARCH.
- Reset applied mid-operation takes priority over any sample on the same edge. No memory of pre-reset state is kept.
- Code convention: the source steps as next = {q[N-2:0], ~q[N-1]} from 0. For N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Legal code: the word is a contiguous run of ones anchored at the LSB (including all-zeros and all-ones), or a contiguous run of ones anchored at the MSB.
- Decode: if q[0]=1 or q=0, count = popcount(q); otherwise count = 2N - popcount(q).
- Decode examples for N=4: 1111 -> 4, 1110 -> 5, 1000 -> 7.
- Latency: every output is registered and reflects the sample taken on the previous enabled edge.
- When enable=0, all outputs hold, except that the error pulses clear to 0.
- State SEARCH:
  - On a legal sample: prev <= decoded value, valid=1.
  - If valid was already 1 and the sample equals prev+1 mod 2N: go to LOCKED, locked=1.
  - On an illegal sample: code_err pulse, valid=0, onehot=0, count holds, stay in SEARCH.
  - No seq_err is raised while in SEARCH.
- State LOCKED:
  - Sample equals prev+1 mod 2N: update outputs and stay in LOCKED.
  - Wrap from 2N-1 to 0 is a legal step.
  - Illegal code: code_err pulse, valid=0, locked=0, go to SEARCH.
  - Legal code with the wrong step (including a hold of the same code): seq_err pulse, outputs take the new decode, prev <= new value, locked=0, go to SEARCH.
- code_err and seq_err are mutually exclusive in any cycle.
- err_cnt increments by 1 per error pulse and saturates at 2^ERRW-1. It clears only on rst.

Decomposition:
- Shared package johnson_pkg holds:
  - localparam CW = $clog2(2N);
  - state enum {SEARCH, LOCKED};
  - functions johnson_is_legal(q) and johnson_to_bin(q).
  - The same package serves the counter's next-state function.
- One combinational sub-module, johnson_code_check, is natural. It takes q_in and returns legal, bin, and onehot.
- johnson_decoder owns the FSM, the prev register, the step comparison, and the error counter.

Test Plan:
- Reset, then drive the counter sequence from 0000 with 15 consecutive enables -> count 0,1,...,7,0,...,6 one cycle after each sample. locked=1 from the second sample onward. No error pulses. err_cnt=0.
- While locked at count=3 (0111), drive q_in=0101 with enable=1 -> code_err=1 for one cycle, valid=0, locked=0, err_cnt=1. Then 0111, 1111 -> relock at count=4.
- While locked at count=2, drive 1110 (step 5) -> seq_err pulse, count=5, locked=0. Then 1100 -> locked=1, count=6.
- Drive 1000 then 0000 -> wrap 7->0 with no error. Drive enable=0 for 4 cycles with garbage on q_in -> outputs unchanged, no pulses.
- Assert rst for one cycle while locked at count=6 -> next cycle all outputs 0 and state SEARCH. Reset overrides a simultaneous enabled sample.
- Drive 300 consecutive illegal codes (1010) with enable=1 and ERRW=8 -> err_cnt saturates at 255 and stays there.

Source files
------------

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson-code types and helper functions
package johnson_pkg;

  // Default register width and the matching step-index width
  localparam int JN = 4;
  localparam int CW = $clog2(2 * JN);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Mask covering the low n bits of a 32-bit word
  function automatic logic [31:0] johnson_mask(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Legal: ones anchored at the LSB, or ones anchored at the MSB (zeros anchored at the LSB)
  function automatic logic johnson_is_legal(input logic [31:0] q, input int n);
    logic [31:0] qm;
    logic [31:0] qc;
    qm = q & johnson_mask(n);
    qc = ~q & johnson_mask(n);
    return ((qm & (qm + 32'd1)) == 32'd0) || ((qc & (qc + 32'd1)) == 32'd0);
  endfunction

  // Step index: popcount on the rising half, 2n - popcount on the falling half
  function automatic int johnson_to_bin(input logic [31:0] q, input int n);
    int pc;
    pc = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && q[i]) pc++;
    end
    if (q[0] || ((q & johnson_mask(n)) == 32'd0)) return pc;
    return 2 * n - pc;
  endfunction

  // Counter next state: shift left, feeding back the inverted MSB
  function automatic logic [31:0] johnson_next(input logic [31:0] q, input int n);
    logic [31:0] qm;
    qm = q & johnson_mask(n);
    return ((qm << 1) | {31'd0, ~qm[n-1]}) & johnson_mask(n);
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - sample and status bundle of the Johnson decoder
interface johnson_decoder_if #(
  parameter int N    = 4,
  parameter int ERRW = 8
);
  localparam int IW = $clog2(2 * N);

  logic            enable;
  logic [N-1:0]    q_in;
  logic [IW-1:0]   count;
  logic [2*N-1:0]  onehot;
  logic            valid;
  logic            locked;
  logic            code_err;
  logic            seq_err;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output enable, q_in,
    input  count, onehot, valid, locked, code_err, seq_err, err_cnt
  );

  modport slave (
    input  enable, q_in,
    output count, onehot, valid, locked, code_err, seq_err, err_cnt
  );
endinterface

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational legality check and decode of one Johnson word
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           q,
  output logic                   legal,
  output logic [$clog2(2*N)-1:0] bin,
  output logic [2*N-1:0]         onehot
);
  localparam int IW = $clog2(2 * N);

  logic [31:0] qx;
  assign qx = 32'(q);

  // Decode is computed regardless of legality; onehot is masked for illegal words
  always_comb begin
    legal  = johnson_is_legal(qx, N);
    bin    = IW'(johnson_to_bin(qx, N));
    onehot = legal ? ({{(2*N-1){1'b0}}, 1'b1} << bin) : '0;
  end
endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder and sequence lock monitor
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N    = 4,
  parameter int ERRW = 8
) (
  input  logic             clk,
  input  logic             rst,
  johnson_decoder_if.slave bus
);
  localparam int IW   = $clog2(2 * N);
  localparam int LAST = 2 * N - 1;

  logic            legal;
  logic [IW-1:0]   bin;
  logic [2*N-1:0]  oh;
  state_t          state;
  logic [IW-1:0]   prev;
  logic [IW-1:0]   prev_inc;
  logic            step_ok;
  logic            err_evt;

  johnson_code_check #(.N(N)) u_check (
    .q      (bus.q_in),
    .legal  (legal),
    .bin    (bin),
    .onehot (oh)
  );

  assign prev_inc = (prev == IW'(LAST)) ? '0 : prev + IW'(1);
  assign step_ok  = (bin == prev_inc);
  assign err_evt  = bus.enable && (!legal || (state == LOCKED && !step_ok));

  // Tracking FSM: decodes each enabled sample and decides lock, loss of lock and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEARCH;
      prev         <= '0;
      bus.count    <= '0;
      bus.onehot   <= '0;
      bus.valid    <= 1'b0;
      bus.locked   <= 1'b0;
      bus.code_err <= 1'b0;
      bus.seq_err  <= 1'b0;
    end else begin
      bus.code_err <= 1'b0;
      bus.seq_err  <= 1'b0;
      if (bus.enable) begin
        if (!legal) begin
          // count keeps the last good decode; prev is untouched
          bus.code_err <= 1'b1;
          bus.valid    <= 1'b0;
          bus.onehot   <= '0;
          bus.locked   <= 1'b0;
          state        <= SEARCH;
        end else begin
          bus.count  <= bin;
          bus.onehot <= oh;
          bus.valid  <= 1'b1;
          prev       <= bin;
          case (state)
            SEARCH: begin
              if (bus.valid && step_ok) begin
                state      <= LOCKED;
                bus.locked <= 1'b1;
              end
            end
            LOCKED: begin
              if (!step_ok) begin
                bus.seq_err <= 1'b1;
                bus.locked  <= 1'b0;
                state       <= SEARCH;
              end
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

  // Saturating tally of code and sequence error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_cnt <= '0;
    end else if (err_evt && (bus.err_cnt != '1)) begin
      bus.err_cnt <= bus.err_cnt + ERRW'(1);
    end
  end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - self-checking bench for johnson_decoder
module tb_johnson_decoder;
  localparam int N    = 4;
  localparam int ERRW = 8;
  localparam int L    = 2 * N;

  logic clk;
  logic rst;

  johnson_decoder_if #(.N(N), .ERRW(ERRW)) bus ();

  johnson_decoder #(.N(N), .ERRW(ERRW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       en;
    logic [3:0] q;
    int         cnt;
    logic       v;
    logic       l;
    logic       ce;
    logic       se;
    int         ec;
  } vec_t;

  vec_t       vq[$];
  logic [3:0] seq_tab[L];
  int         lut[16];
  int         checks;
  int         failures;

  // reference model state
  int   m_cnt, m_prev, m_ec;
  logic m_v, m_l, m_ce, m_se;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic en, input logic [3:0] q, input int cnt,
                              input logic v, input logic l, input logic ce, input logic se,
                              input int ec);
    vec_t x;
    x.r = r; x.en = en; x.q = q; x.cnt = cnt; x.v = v; x.l = l; x.ce = ce; x.se = se; x.ec = ec;
    vq.push_back(x);
  endfunction

  task automatic drive(input logic r, input logic en, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    bus.enable = en;
    bus.q_in = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int cnt, input logic v, input logic l,
                           input logic ce, input logic se, input int ec);
    logic [7:0] oh;
    oh = v ? (8'd1 << cnt) : 8'd0;
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".onehot"}, 32'(bus.onehot), 32'(oh));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".locked"}, 32'(bus.locked), 32'(l));
    chk({tag, ".code_err"}, 32'(bus.code_err), 32'(ce));
    chk({tag, ".seq_err"}, 32'(bus.seq_err), 32'(se));
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(ec));
  endtask

  task automatic model_step(input logic r, input logic en, input logic [3:0] q);
    int idx;
    int nxt;
    m_ce = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_cnt = 0; m_prev = 0; m_ec = 0; m_v = 1'b0; m_l = 1'b0;
    end else if (en) begin
      idx = lut[q];
      nxt = (m_prev + 1) % L;
      if (idx < 0) begin
        m_ce = 1'b1; m_v = 1'b0; m_l = 1'b0;
        if (m_ec < 255) m_ec++;
      end else begin
        if (m_l && idx != nxt) begin
          m_se = 1'b1; m_l = 1'b0;
          if (m_ec < 255) m_ec++;
        end else if (!m_l && m_v && idx == nxt) begin
          m_l = 1'b1;
        end
        m_cnt = idx; m_prev = idx; m_v = 1'b1;
      end
    end
  endtask

  initial begin
    logic [3:0] qq;
    int         k;
    int         sel;
    logic       r, en;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.q_in = 4'd0;

    // legal code table built by stepping the source rule from 0000
    for (int i = 0; i < 16; i++) lut[i] = -1;
    qq = 4'b0000;
    for (int i = 0; i < L; i++) begin
      seq_tab[i] = qq;
      lut[qq] = i;
      qq = {qq[2:0], ~qq[3]};
    end

    // directed table
    add(1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, seq_tab[i % L], i % L, 1, (i >= 1), 0, 0, 0);
    for (int i = 7; i < 12; i++) add(0, 1, seq_tab[i % L], i % L, 1, 1, 0, 0, 0);
    add(0, 1, 4'b0101, 3, 0, 0, 1, 0, 1);
    add(0, 1, 4'b0111, 3, 1, 0, 0, 0, 1);
    add(0, 1, 4'b1111, 4, 1, 1, 0, 0, 1);
    for (int i = 5; i < 11; i++) add(0, 1, seq_tab[i % L], i % L, 1, 1, 0, 0, 1);
    add(0, 1, 4'b1110, 5, 1, 0, 0, 1, 2);
    add(0, 0, 4'b1010, 5, 1, 0, 0, 0, 2);
    add(0, 1, 4'b1100, 6, 1, 1, 0, 0, 2);
    add(0, 1, 4'b1000, 7, 1, 1, 0, 0, 2);
    add(0, 1, 4'b0000, 0, 1, 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) add(0, 0, 4'($urandom), 0, 1, 1, 0, 0, 2);
    for (int i = 1; i < 7; i++) add(0, 1, seq_tab[i], i, 1, 1, 0, 0, 2);
    add(1, 1, 4'b0111, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b0111, 3, 1, 0, 0, 0, 0);
    add(0, 1, 4'b0111, 3, 1, 0, 0, 0, 0);
    add(0, 1, 4'b1111, 4, 1, 1, 0, 0, 0);
    add(0, 1, 4'b1111, 4, 1, 0, 0, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].r, vq[i].en, vq[i].q);
      check_all($sformatf("vec%0d", i), vq[i].cnt, vq[i].v, vq[i].l, vq[i].ce, vq[i].se, vq[i].ec);
    end

    // error counter saturation
    drive(1, 0, 4'd0);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 4'b1010);
      chk("sat.err_cnt", 32'(bus.err_cnt), 32'((i + 1 < 255) ? i + 1 : 255));
      chk("sat.code_err", 32'(bus.code_err), 32'd1);
    end
    drive(0, 0, 4'b1010);
    chk("sat.hold", 32'(bus.err_cnt), 32'd255);
    chk("sat.pulse_clear", 32'(bus.code_err), 32'd0);

    // randomized run against the reference model
    drive(1, 0, 4'd0);
    model_step(1, 0, 4'd0);
    check_all("rnd_rst", m_cnt, m_v, m_l, m_ce, m_se, m_ec);
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 4) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 6) qq = seq_tab[(m_prev + 1) % L];
      else if (sel < 8) begin
        k = $urandom_range(0, L - 1);
        qq = seq_tab[k];
      end else qq = 4'($urandom);
      drive(r, en, qq);
      model_step(r, en, qq);
      check_all($sformatf("rnd%0d", i), m_cnt, m_v, m_l, m_ce, m_se, m_ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
